// File: rtl/tlrb_aib_tx_pkg.sv
// Shared line-word format for the AIB TX framer: header/type codes, marker
// pattern, line-word struct, FSM state type and line-word builders.
package tlrb_aib_tx_pkg;

    localparam int PAYLOAD_W = 72;
    localparam int SEQ_W     = 6;

    localparam logic [1:0]  HDR_DATA   = 2'b01;
    localparam logic [1:0]  HDR_CTRL   = 2'b10;
    localparam logic [7:0]  CTL_IDLE   = 8'h3C;
    localparam logic [7:0]  CTL_AM     = 8'hA5;
    localparam logic [63:0] AM_PATTERN = 64'h0F0F_5A5A_C3C3_A5A5;

    typedef struct packed {
        logic [1:0]  hdr;
        logic [77:0] body;
    } tx_line_t;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_START,
        ST_RUN
    } tx_fr_state_e;

    function automatic tx_line_t line_data(input logic [SEQ_W-1:0]     seq,
                                           input logic [PAYLOAD_W-1:0] payload);
        tx_line_t l;
        l.hdr  = HDR_DATA;
        l.body = {seq, payload};
        return l;
    endfunction

    function automatic tx_line_t line_idle();
        tx_line_t l;
        l.hdr  = HDR_CTRL;
        l.body = {CTL_IDLE, 70'h0};
        return l;
    endfunction

    // The marker advertises the sequence number the next data word will carry.
    function automatic tx_line_t line_marker(input logic [SEQ_W-1:0] seq);
        tx_line_t l;
        l.hdr  = HDR_CTRL;
        l.body = {CTL_AM, seq, AM_PATTERN};
        return l;
    endfunction

endpackage

// File: rtl/tlrb_aib_tx_fifo.sv
// Single-clock synchronous FIFO with occupancy count; storage is not reset,
// only the pointers and count are.
module tlrb_aib_tx_fifo #(
    parameter int DATA_W = 72,
    parameter int DEPTH  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/tlrb_aib_tx_framer.sv
// AIB TX framer: buffers 72-bit payload beats and emits one registered 80-bit
// line word per cycle (data, idle, or periodic alignment marker).
module tlrb_aib_tx_framer
    import tlrb_aib_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int AM_PERIOD  = 1024
) (
    input  logic        tx_clk,
    input  logic        tx_rst,
    input  logic        link_up,
    input  logic        tx_en,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [71:0] s_data,
    output logic [79:0] tx_data,
    output logic        am_sent,
    output logic [5:0]  seq_out
);
    localparam int AMW = $clog2(AM_PERIOD);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [AMW-1:0] AM_LAST  = AMW'(AM_PERIOD - 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(FIFO_DEPTH);

    tx_fr_state_e         state_q, state_d;
    logic [AMW-1:0]       am_cnt_q, am_cnt_d;
    logic [SEQ_W-1:0]     seq_q, seq_d;
    tx_line_t             line_q, line_d;
    logic                 am_sent_q, am_sent_d;
    logic                 s_ready_q;

    logic                 link_ok;
    logic                 accept;
    logic                 bypass;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [PAYLOAD_W-1:0] fifo_rdata;
    logic [CW-1:0]        fifo_count;
    logic [CW-1:0]        count_nxt;

    assign link_ok = link_up && tx_en;
    assign accept  = s_valid && s_ready_q;

    // A beat arriving into an empty FIFO when a data slot is free goes
    // straight to the line register instead of being buffered.
    assign fifo_push = accept && !bypass && !fifo_full;
    assign count_nxt = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

    tlrb_aib_tx_fifo #(
        .DATA_W (PAYLOAD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (tx_clk),
        .rst_i   (tx_rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (s_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        am_cnt_d  = am_cnt_q;
        seq_d     = seq_q;
        line_d    = '0;
        am_sent_d = 1'b0;
        fifo_pop  = 1'b0;
        bypass    = 1'b0;

        if (!link_ok) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d   = ST_START;
                    line_d    = line_marker(seq_q);
                    am_sent_d = 1'b1;
                    am_cnt_d  = '0;
                end
                default: begin
                    state_d = ST_RUN;
                    if (am_cnt_q == AM_LAST) begin
                        line_d    = line_marker(seq_q);
                        am_sent_d = 1'b1;
                        am_cnt_d  = '0;
                    end else begin
                        am_cnt_d = am_cnt_q + AMW'(1);
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            line_d   = line_data(seq_q, fifo_rdata);
                            seq_d    = seq_q + 6'd1;
                        end else if (accept) begin
                            bypass = 1'b1;
                            line_d = line_data(seq_q, s_data);
                            seq_d  = seq_q + 6'd1;
                        end else begin
                            line_d = line_idle();
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state_q   <= ST_OFF;
            am_cnt_q  <= '0;
            seq_q     <= '0;
            line_q    <= '0;
            am_sent_q <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            am_cnt_q  <= am_cnt_d;
            seq_q     <= seq_d;
            line_q    <= line_d;
            am_sent_q <= am_sent_d;
            s_ready_q <= (count_nxt != CNT_FULL);
        end
    end

    assign tx_data = line_q;
    assign am_sent = am_sent_q;
    assign seq_out = seq_q;
    assign s_ready = s_ready_q;

endmodule
